// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Lets two requesters share one combinational ALU. Each cycle at most one
// request is granted, with round-robin priority when both ports ask. The
// granted operands and opcode go out to the ALU. The ALU result and equality
// flag are registered and handed back to the winning port on the next cycle.
// There is no request buffering: a losing requester must hold its request.

module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,

    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [OPW-1:0]   op0,
    output logic             gnt0,

    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [OPW-1:0]   op1,
    output logic             gnt1,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_eq,

    output logic             rsp_valid0,
    output logic             rsp_valid1,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_eq,
    output logic [15:0]      busy_cnt
);

    // Index of the port granted most recently. It resets to 1, so port 0
    // wins the first conflict after reset.
    logic last;
    logic conflict;

    assign conflict = req0 && req1 && !hold;

    // Grant decision: a lone requester always wins. On a conflict, the port
    // that did not win last time gets the grant.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!hold) begin
            if (req0 && req1) begin
                gnt0 = last;
                gnt1 = !last;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // ALU operand mux. Port 1 drives the ALU only while it holds the grant.
    // At all other times port 0 drives it, so idle cycles are still deterministic.
    always_comb begin
        if (gnt1) begin
            alu_a  = a1;
            alu_b  = b1;
            alu_op = op1;
        end else begin
            alu_a  = a0;
            alu_b  = b0;
            alu_op = op0;
        end
    end

    // Round-robin pointer, response registers and conflict counter.
    // Reset takes priority, so an operation granted in a reset cycle is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            last       <= 1'b1;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            rsp_res    <= '0;
            rsp_eq     <= 1'b0;
            busy_cnt   <= '0;
        end else begin
            rsp_valid0 <= gnt0;
            rsp_valid1 <= gnt1;
            if (gnt0 || gnt1) begin
                last    <= gnt1;
                rsp_res <= alu_res;
                rsp_eq  <= alu_eq;
            end
            if (conflict && (busy_cnt != 16'hFFFF)) begin
                busy_cnt <= busy_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter. A behavioural ALU model drives the shared
// ALU inputs. The stimulus process predicts grants and pushes each expected
// response into a queue. A separate monitor process pops that queue and
// compares it against every response the DUT presents.

module tb_alu_share_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 3;

    logic             clk = 1'b0;
    logic             reset, hold;
    logic             req0, req1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [OPW-1:0]   op0, op1;
    logic             gnt0, gnt1;
    logic [WIDTH-1:0] alu_a, alu_b, alu_res;
    logic [OPW-1:0]   alu_op;
    logic             alu_eq;
    logic             rsp_valid0, rsp_valid1, rsp_eq;
    logic [WIDTH-1:0] rsp_res;
    logic [15:0]      busy_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;

    typedef struct {
        int               tag;
        bit               port;
        logic [WIDTH-1:0] res;
        bit               eq;
    } rsp_t;

    rsp_t exp_q[$];

    // Reference model state, updated from the spec rules.
    bit               m_last;
    int               m_busy;
    logic [WIDTH-1:0] m_res;
    bit               m_eq;

    alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .req0(req0), .a0(a0), .b0(b0), .op0(op0), .gnt0(gnt0),
        .req1(req1), .a1(a1), .b1(b1), .op1(op1), .gnt1(gnt1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_eq(alu_eq),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_res(rsp_res), .rsp_eq(rsp_eq), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_fn(logic [OPW-1:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return {b[15:0], 16'h0000};
            default: return '0;
        endcase
    endfunction

    // Shared ALU seen by the arbiter.
    always_comb begin
        alu_res = alu_fn(alu_op, alu_a, alu_b);
        alu_eq  = (alu_a == alu_b);
    end

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc_cnt, act, exp);
        end
    endtask

    // Monitor: consumes the expected queue whenever a response is presented.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid0 === 1'b1 || rsp_valid1 === 1'b1) begin
                chk("rsp_onehot", {31'd0, rsp_valid0 & rsp_valid1}, 32'd0);
                if (exp_q.size() == 0 || exp_q[0].tag != cyc_cnt - 1) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_valid0", {31'd0, rsp_valid0}, {31'd0, !e.port});
                    chk("rsp_valid1", {31'd0, rsp_valid1}, {31'd0, e.port});
                    chk("rsp_res", rsp_res, e.res);
                    chk("rsp_eq", {31'd0, rsp_eq}, {31'd0, e.eq});
                end
            end else if (exp_q.size() != 0 && exp_q[0].tag <= cyc_cnt - 1) begin
                e = exp_q.pop_front();
                chk("rsp_missing", 32'd0, 32'd1);
            end
        end
    end

    // One clock of stimulus: drive the inputs, check combinational grants and
    // registered state against the model, then advance the model.
    task automatic cycle(bit r0, logic [31:0] ia0, logic [31:0] ib0, logic [2:0] iop0,
                         bit r1, logic [31:0] ia1, logic [31:0] ib1, logic [2:0] iop1,
                         bit h, bit rst);
        bit   eg0, eg1;
        rsp_t e;
        @(posedge clk);
        #1;
        req0 = r0; a0 = ia0; b0 = ib0; op0 = iop0;
        req1 = r1; a1 = ia1; b1 = ib1; op1 = iop1;
        hold = h;  reset = rst;
        #3;
        if (h) begin
            eg0 = 0; eg1 = 0;
        end else if (r0 && r1) begin
            eg0 = (m_last == 1'b1); eg1 = !eg0;
        end else begin
            eg0 = r0; eg1 = r1;
        end
        chk("gnt0", {31'd0, gnt0}, {31'd0, eg0});
        chk("gnt1", {31'd0, gnt1}, {31'd0, eg1});
        chk("busy_cnt", {16'd0, busy_cnt}, m_busy);
        chk("rsp_res_reg", rsp_res, m_res);
        chk("rsp_eq_reg", {31'd0, rsp_eq}, {31'd0, m_eq});
        if (rst) begin
            m_last = 1; m_busy = 0; m_res = '0; m_eq = 0;
        end else begin
            if (eg0 || eg1) begin
                e.tag  = cyc_cnt;
                e.port = eg1;
                e.res  = eg1 ? alu_fn(iop1, ia1, ib1) : alu_fn(iop0, ia0, ib0);
                e.eq   = eg1 ? (ia1 == ib1) : (ia0 == ib0);
                exp_q.push_back(e);
                m_last = eg1;
                m_res  = e.res;
                m_eq   = e.eq;
            end
            if (r0 && r1 && !h && m_busy < 65535) m_busy++;
        end
    endtask

    task automatic idle(bit rst);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, rst);
    endtask

    initial begin
        logic [31:0] ra0, rb0, ra1, rb1;
        reset = 1; hold = 0; req0 = 0; req1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; op0 = 0; op1 = 0;
        m_last = 1; m_busy = 0; m_res = '0; m_eq = 0;
        // The model is only valid once reset has been sampled.
        @(posedge clk);
        idle(1);
        idle(0);

        // Single add on port 0.
        cycle(1, 5, 3, 3'd0, 0, 0, 0, 0, 0, 0);
        idle(0);

        // Four cycles of conflict, SUBU versus OR.
        idle(1);
        for (int i = 0; i < 4; i++)
            cycle(1, 10, 4, 3'd1, 1, 32'hF0, 32'h0F, 3'd3, 0, 0);
        idle(0);

        // LUI on port 1, then a conflict that port 0 should win.
        cycle(0, 0, 0, 0, 1, 0, 32'h1234, 3'd4, 0, 0);
        cycle(1, 1, 2, 3'd2, 1, 3, 4, 3'd0, 0, 0);
        idle(0);

        // Hold with both requesting, then release.
        for (int i = 0; i < 3; i++)
            cycle(1, 9, 9, 3'd0, 1, 8, 1, 3'd1, 1, 0);
        cycle(1, 9, 9, 3'd0, 1, 8, 1, 3'd1, 0, 0);
        cycle(1, 9, 9, 3'd0, 1, 8, 1, 3'd1, 0, 0);
        idle(0);

        // Equal operands, then an undefined opcode.
        cycle(1, 7, 7, 3'd1, 0, 0, 0, 0, 0, 0);
        cycle(1, 32'h55, 32'h33, 3'd7, 0, 0, 0, 0, 0, 0);
        idle(0);

        // Reset during a grant; the next conflict goes to port 0.
        cycle(1, 6, 6, 3'd0, 1, 2, 2, 3'd0, 0, 0);
        cycle(1, 6, 6, 3'd0, 0, 0, 0, 0, 0, 1);
        cycle(1, 1, 1, 3'd3, 1, 2, 2, 3'd3, 0, 0);
        idle(0);

        // Randomized traffic with occasional hold and reset.
        for (int i = 0; i < 3000; i++) begin
            ra0 = $urandom; rb0 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
            ra1 = $urandom; rb1 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
            cycle($urandom_range(0, 3) != 0, ra0, rb0, 3'($urandom),
                  $urandom_range(0, 3) != 0, ra1, rb1, 3'($urandom),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
        end

        idle(0);
        idle(0);
        @(posedge clk);
        #4;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
